memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Two-port (instruction / data) arbiter in front of a single-outstanding
// memory interface. Each port owns one request slot; grants alternate between
// the ports when both compete, and a BUSY watchdog aborts a transaction whose
// response never arrives.
module memory_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_valid,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    output logic [31:0] i_rdata,
    output logic        i_ready,

    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ready,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,

    output logic        arb_err
);

    // Counter wide enough to hold TIMEOUT-1; at least one bit.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Port index 0 = instruction, 1 = data.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t          state_reg, state_next;

    logic [1:0]      p_valid;
    logic [31:0]     p_addr_in  [2];
    logic [31:0]     p_wdata_in [2];
    logic [3:0]      p_wstrb_in [2];

    logic [1:0]      pend_reg;
    logic [1:0]      busy_reg;
    logic [31:0]     slot_addr_reg  [2];
    logic [31:0]     slot_wdata_reg [2];
    logic [3:0]      slot_wstrb_reg [2];

    logic [1:0]      accept;
    logic [1:0]      cand;
    logic [1:0]      p_ready;
    logic [31:0]     p_rdata [2];

    logic            last_grant_reg;
    logic [CW-1:0]   cnt_reg;

    logic            mem_valid_reg;
    logic            mem_instr_reg;
    logic [31:0]     mem_addr_reg;
    logic [31:0]     mem_wdata_reg;
    logic [3:0]      mem_wstrb_reg;

    logic            grant_en;
    logic            grant_sel;
    logic            done;
    logic            tmo;
    logic [31:0]     g_addr;
    logic [31:0]     g_wdata;
    logic [3:0]      g_wstrb;

    assign p_valid       = {d_valid, i_valid};
    assign p_addr_in[0]  = i_addr;
    assign p_addr_in[1]  = d_addr;
    assign p_wdata_in[0] = i_wdata;
    assign p_wdata_in[1] = d_wdata;
    assign p_wstrb_in[0] = i_wstrb;
    assign p_wstrb_in[1] = d_wstrb;

    assign i_ready = p_ready[0];
    assign d_ready = p_ready[1];
    assign i_rdata = p_rdata[0];
    assign d_rdata = p_rdata[1];

    assign mem_valid = mem_valid_reg;
    assign mem_instr = mem_instr_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;

    // Per-port slot logic: acceptance, pending flag, busy flag, captured request.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            // A busy port only takes a new request in the cycle its ready fires.
            assign accept[gi] = p_valid[gi] && (!busy_reg[gi] || p_ready[gi]);
            // Pending and same-cycle accept are mutually exclusive while IDLE,
            // because no ready can fire in IDLE.
            assign cand[gi]   = pend_reg[gi] || accept[gi];

            // Captured request fields follow any accepted valid.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    slot_addr_reg[gi]  <= '0;
                    slot_wdata_reg[gi] <= '0;
                    slot_wstrb_reg[gi] <= '0;
                end else if (accept[gi]) begin
                    slot_addr_reg[gi]  <= p_addr_in[gi];
                    slot_wdata_reg[gi] <= p_wdata_in[gi];
                    slot_wstrb_reg[gi] <= p_wstrb_in[gi];
                end
            end

            // Pending clears when granted; busy spans accept through ready.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pend_reg[gi] <= 1'b0;
                    busy_reg[gi] <= 1'b0;
                end else begin
                    if (grant_en && (grant_sel == gi[0]))
                        pend_reg[gi] <= 1'b0;
                    else if (accept[gi])
                        pend_reg[gi] <= 1'b1;

                    if (accept[gi])
                        busy_reg[gi] <= 1'b1;
                    else if (p_ready[gi])
                        busy_reg[gi] <= 1'b0;
                end
            end

            // Response routing: only the owner sees ready, and data only on a real response.
            assign p_rdata[gi] = (p_ready[gi] && mem_ready) ? mem_rdata : 32'h0;
        end
    endgenerate

    // Granted request comes from the slot if it was waiting, else straight from the port.
    assign g_addr  = pend_reg[grant_sel] ? slot_addr_reg[grant_sel]  : p_addr_in[grant_sel];
    assign g_wdata = pend_reg[grant_sel] ? slot_wdata_reg[grant_sel] : p_wdata_in[grant_sel];
    assign g_wstrb = pend_reg[grant_sel] ? slot_wstrb_reg[grant_sel] : p_wstrb_in[grant_sel];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state, grant selection, completion and timeout decode.
    always_comb begin
        state_next = state_reg;
        grant_en   = 1'b0;
        grant_sel  = PORT_I;
        done       = 1'b0;
        tmo        = 1'b0;
        p_ready    = 2'b00;
        arb_err    = 1'b0;

        case (state_reg)
            IDLE: begin
                // Late responses in IDLE fall through untouched.
                if (cand == 2'b11)
                    grant_sel = ~last_grant_reg;
                else if (cand[1])
                    grant_sel = PORT_D;
                else
                    grant_sel = PORT_I;
                if (|cand) begin
                    grant_en   = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // A response in the expiry cycle wins over the abort.
                tmo  = (TIMEOUT > 0) && (cnt_reg == CW'(TIMEOUT - 1)) && !mem_ready;
                done = mem_ready || tmo;
                if (done) begin
                    p_ready[0] = mem_instr_reg;
                    p_ready[1] = !mem_instr_reg;
                    arb_err    = tmo;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Round-robin memory: remembers the winner of the last contested grant,
    // so uncontested grants do not disturb the alternation between pairs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_grant_reg <= PORT_D;
        else if (grant_en && (cand == 2'b11))
            last_grant_reg <= grant_sel;
    end

    // BUSY cycle counter: zero on the first BUSY cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_reg <= '0;
        else if (grant_en)
            cnt_reg <= '0;
        else if ((state_reg == BUSY) && (TIMEOUT > 0) && (cnt_reg != {CW{1'b1}}))
            cnt_reg <= cnt_reg + CW'(1);
    end

    // Downstream request: one-cycle valid pulse, fields held until the next grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid_reg <= 1'b0;
            mem_instr_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
        end else begin
            mem_valid_reg <= grant_en;
            if (grant_en) begin
                mem_instr_reg <= (grant_sel == PORT_I);
                mem_addr_reg  <= g_addr;
                mem_wdata_reg <= g_wdata;
                mem_wstrb_reg <= g_wstrb;
            end
        end
    end

endmodule
